// File: rtl/mult_booth_r4.sv
// mult_booth_r4: iterative radix-4 Booth multiplier with a signed/unsigned mode, full product and ready/busy handshake
module mult_booth_r4 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clr_n,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic             ctrl_MULT,
  input  logic             signed_mode,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             exception,
  output logic             rdy,
  output logic             busy
);
  localparam int ITER = (WIDTH + 2) / 2;
  localparam int EW = WIDTH + 2;
  localparam int AW = WIDTH + 4;
  localparam int TW = AW + EW + 1;
  localparam int CW = $clog2(ITER + 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0] state_q, state_d;
  logic [EW-1:0] mcand_q, mcand_d, mplr_q, mplr_d;
  logic qh_q, qh_d, smode_q, smode_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  logic exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;
  logic run, last;
  logic [2:0] digit;
  logic [AW-1:0] m_ext, addend, sum;
  logic signed [TW-1:0] sh;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0] top;
  always_comb begin
    run = state_q == RUN;
    last = run && cnt_q == CW'(ITER - 1);
    m_ext = {{2{mcand_q[EW-1]}}, mcand_q};
    digit = {mplr_q[1:0], qh_q};
    addend = (digit == 3'b001 || digit == 3'b010) ? m_ext :
             digit == 3'b011 ? {m_ext[AW-2:0], 1'b0} :
             digit == 3'b100 ? -{m_ext[AW-2:0], 1'b0} :
             (digit == 3'b101 || digit == 3'b110) ? -m_ext : '0;
    sum = acc_q + addend;
    sh = $signed({sum, mplr_q, qh_q}) >>> 2;
    prod = {sh[EW+WIDTH-2:EW+1], sh[EW:1]};
    top = prod[2*WIDTH-1:WIDTH-1];
    state_d = ctrl_MULT ? RUN : last ? DONE : state_q;
    mcand_d = ctrl_MULT ? (signed_mode ? {{2{dataA[WIDTH-1]}}, dataA} : {2'b00, dataA}) : mcand_q;
    mplr_d = ctrl_MULT ? (signed_mode ? {{2{dataB[WIDTH-1]}}, dataB} : {2'b00, dataB}) :
             run ? sh[EW:1] : mplr_q;
    smode_d = ctrl_MULT ? signed_mode : smode_q;
    acc_d = ctrl_MULT ? '0 : run ? sh[TW-1:EW+1] : acc_q;
    qh_d = ctrl_MULT ? 1'b0 : run ? sh[0] : qh_q;
    cnt_d = ctrl_MULT ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    result_d = (last && !ctrl_MULT) ? prod[WIDTH-1:0] : result_q;
    result_hi_d = (last && !ctrl_MULT) ? prod[2*WIDTH-1:WIDTH] : result_hi_q;
    exc_d = (last && !ctrl_MULT) ? (smode_q ? !((&top) || !(|top)) : |prod[2*WIDTH-1:WIDTH]) : exc_q;
    rdy_d = ctrl_MULT ? 1'b0 : last ? 1'b1 : rdy_q;
    busy_d = ctrl_MULT ? 1'b1 : last ? 1'b0 : busy_q;
  end
  always_ff @(posedge clock or negedge clr_n)
    if (!clr_n) begin
      state_q <= IDLE;
      mcand_q <= '0;
      mplr_q <= '0;
      qh_q <= 1'b0;
      smode_q <= 1'b0;
      acc_q <= '0;
      cnt_q <= '0;
      result_q <= '0;
      result_hi_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplr_q <= mplr_d;
      qh_q <= qh_d;
      smode_q <= smode_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      exc_q <= exc_d;
      rdy_q <= rdy_d;
      busy_q <= busy_d;
    end
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign exception = exc_q;
  assign rdy = rdy_q;
  assign busy = busy_q;
endmodule
